// File: rtl/trng_pool_pkg.sv
// Shared types and defaults for the TRNG key pool.
// State encoding plus default geometry constants.
package trng_pool_pkg;

  typedef enum logic [1:0] {
    ST_WAIT  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FAIL  = 2'd2
  } state_t;

  localparam int TRNG_WORD_W = 32;
  localparam int POOL_DEPTH  = 8;
  localparam int REP_LIMIT   = 3;
  localparam int POP_MIN     = 8;
  localparam int REJ_CNT_W   = 8;

endpackage

// File: rtl/trng_key_fifo.sv
// Show-ahead FIFO holding health-checked key words.
// Flush wins over a same-cycle push or pop.
module trng_key_fifo #(
  parameter int WORD_W = 32,
  parameter int DEPTH  = 8,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              flush,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata,
  output logic              full,
  output logic              empty,
  output logic [AW:0]       level
);

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == FULL_LVL);
  assign empty   = (count == '0);
  assign level   = count;
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads as zero when empty so the output has a defined reset value.
  assign rdata   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/trng_key_pool.sv
// Harvests TRNG words, health-tests them and serves
// passing words as key material through a FIFO.
module trng_key_pool #(
  parameter int WORD_W    = trng_pool_pkg::TRNG_WORD_W,
  parameter int DEPTH     = trng_pool_pkg::POOL_DEPTH,
  parameter int REP_LIMIT = trng_pool_pkg::REP_LIMIT,
  parameter int POP_MIN   = trng_pool_pkg::POP_MIN
) (
  input  logic                     wb_clk_i,
  input  logic                     rst_ni,
  input  logic                     trng_valid_i,
  input  logic [WORD_W-1:0]        trng_data_i,
  input  logic                     clear_i,
  input  logic                     key_ready_i,
  output logic                     key_valid_o,
  output logic [WORD_W-1:0]        key_data_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     health_fail_o,
  output logic [7:0]               reject_cnt_o
);

  import trng_pool_pkg::*;

  localparam int GW = $clog2(WORD_W);
  localparam int RW = $clog2(REP_LIMIT + 1);
  localparam logic [GW-1:0] GAP_MAX = GW'(WORD_W - 1);
  localparam logic [RW-1:0] REP_MAX = RW'(REP_LIMIT);

  state_t                 state;
  state_t                 state_nx;
  logic [GW-1:0]          gap;
  logic [WORD_W-1:0]      cand;
  logic [WORD_W-1:0]      last;
  logic [RW-1:0]          rep_cnt;
  logic [RW-1:0]          rep_nx;
  logic [REJ_CNT_W-1:0]   reject_cnt;
  int                     ones;
  logic                   pass;
  logic                   rep_hit;
  logic                   in_check;
  logic                   capture;
  logic                   push;
  logic                   pop;
  logic                   full;
  logic                   empty;

  assign in_check = (state == ST_CHECK);
  assign capture  = (state == ST_WAIT) & trng_valid_i
                  & (gap == '0) & ~full & ~clear_i;
  assign ones     = $countones(cand);
  assign pass     = (ones >= POP_MIN) && (ones <= WORD_W - POP_MIN);
  assign rep_nx   = (cand == last) ? rep_cnt + 1'b1 : RW'(1);
  assign rep_hit  = pass & (rep_nx == REP_MAX);
  assign push     = in_check & pass & ~rep_hit & ~clear_i;
  assign pop      = key_valid_o & key_ready_i;

  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= ST_WAIT;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear_i) begin
      state_nx = ST_WAIT;
    end else begin
      unique case (state)
        ST_WAIT:  if (capture) state_nx = ST_CHECK;
        ST_CHECK: state_nx = rep_hit ? ST_FAIL : ST_WAIT;
        ST_FAIL:  state_nx = ST_FAIL;
        default:  state_nx = ST_WAIT;
      endcase
    end
  end

  always_comb begin
    health_fail_o = (state == ST_FAIL);
    key_valid_o   = ~empty & ~health_fail_o;
    reject_cnt_o  = reject_cnt;
  end

  // Rejected words leave the repetition history untouched.
  always_ff @(posedge wb_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      gap        <= GAP_MAX;
      cand       <= '0;
      last       <= '0;
      rep_cnt    <= '0;
      reject_cnt <= '0;
    end else if (clear_i) begin
      gap        <= GAP_MAX;
      last       <= '0;
      rep_cnt    <= '0;
      reject_cnt <= '0;
    end else begin
      if (capture) begin
        cand <= trng_data_i;
        gap  <= GAP_MAX;
      end else if (gap != '0) begin
        gap <= gap - 1'b1;
      end
      if (in_check && pass) begin
        rep_cnt <= rep_nx;
        last    <= cand;
      end
      if (in_check && !pass && reject_cnt != '1)
        reject_cnt <= reject_cnt + 1'b1;
    end
  end

  trng_key_fifo #(
    .WORD_W (WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (wb_clk_i),
    .rst_n (rst_ni),
    .push  (push),
    .pop   (pop),
    .flush (clear_i),
    .wdata (cand),
    .rdata (key_data_o),
    .full  (full),
    .empty (empty),
    .level (level_o)
  );

endmodule
